// File: rtl/seg_scan_if.sv
// Bus bundle between the seven-segment scan controller and its surroundings:
// digit writes, enables, the external decoder loop and the display drive lines.
interface seg_scan_if;
  logic       run;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] en_mask;
  logic [7:0] dp;
  logic [3:0] code;
  logic [7:0] patt_in;
  logic [7:0] seg;
  logic [7:0] an;
  logic       frame_done;

  modport slave (
    input  run, wr_en, wr_addr, wr_data, en_mask, dp, patt_in,
    output code, seg, an, frame_done
  );

  modport master (
    output run, wr_en, wr_addr, wr_data, en_mask, dp, patt_in,
    input  code, seg, an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display, with a
// dead-time phase before each digit and a one-cycle end-of-frame pulse.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GHOST_CYC = 500
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned CntMax = (SCAN_DIV > GHOST_CYC) ? SCAN_DIV : GHOST_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GhostLast = CntW'((GHOST_CYC == 0) ? 0 : GHOST_CYC - 1);
  localparam logic [2:0]      IdxLast   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StGhost, StShow} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      an_q, an_d;
  logic            frame_done_q, frame_done_d;
  logic [3:0]      mem_q [DIGITS];

  logic show_end;
  logic wr_hit;

  assign show_end = (state_q == StShow) && (cnt_q == ShowLast);
  assign wr_hit   = bus.wr_en && ({29'd0, bus.wr_addr} < DIGITS);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    an_d         = 8'hFF;

    // Dropping run wins over any terminal count in the same cycle.
    if (!bus.run) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = (GHOST_CYC == 0) ? StShow : StGhost;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StGhost: begin
          if (cnt_q == GhostLast) begin
            cnt_d   = '0;
            state_d = StShow;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          if (show_end) begin
            cnt_d        = '0;
            idx_d        = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
            state_d      = (GHOST_CYC == 0) ? StShow : StGhost;
            frame_done_d = (idx_q == IdxLast);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A masked digit keeps its slot time but its anode stays dark.
    if (state_d == StShow) begin
      an_d[idx_d] = ~bus.en_mask[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      an_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // The decoder's own decimal-point bit is deliberately discarded.
  logic unused_dec_dp;
  assign unused_dec_dp = bus.patt_in[7];

  assign bus.code       = mem_q[idx_q];
  assign bus.seg        = (state_q == StShow) ? {~bus.dp[idx_q], bus.patt_in[6:0]} : 8'hFF;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
